pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_pkg.sv | 23 ++
 rtl/pixel_writer_if.sv | 40 ++++
 rtl/pixel_writer_wr_out_reg.sv | 59 +++++
 rtl/pixel_writer.sv | 141 ++++++++++++++
 tb/tb_pixel_writer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel writer: FSM states, the RGB444 word width
// and the RGB888 -> RGB444 packing helper.
package pixel_pkg;

  localparam int unsigned RGB444_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  // Keeps the top nibble of each component: {r[7:4], g[7:4], b[7:4]}.
  function automatic logic [RGB444_W-1:0] pack_rgb444(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {r[7:4], g[7:4], b[7:4]};
  endfunction

endpackage

// File: rtl/pixel_writer_if.sv
// Header, pixel-stream and frame-buffer write signals of the pixel writer.
// The slave modport is the writer itself; the master modport is its environment.
interface pixel_writer_if #(
  parameter int unsigned ADDR_W = 17
);
  import pixel_pkg::*;

  logic                hdr_valid;
  logic [15:0]         height;
  logic [15:0]         width;
  logic                pix_valid;
  logic [7:0]          pix_r;
  logic [7:0]          pix_g;
  logic [7:0]          pix_b;
  logic                pix_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [RGB444_W-1:0] wr_data;
  logic                wr_ready;
  logic                frame_done;
  logic                busy;
  logic                hdr_err;

  modport slave (
    input  hdr_valid, height, width,
    input  pix_valid, pix_r, pix_g, pix_b,
    input  wr_ready,
    output pix_ready, wr_en, wr_addr, wr_data,
    output frame_done, busy, hdr_err
  );

  modport master (
    output hdr_valid, height, width,
    output pix_valid, pix_r, pix_g, pix_b,
    output wr_ready,
    input  pix_ready, wr_en, wr_addr, wr_data,
    input  frame_done, busy, hdr_err
  );

endinterface

// File: rtl/pixel_writer_wr_out_reg.sv
// Single-entry valid/ready pipeline register holding one pending frame-buffer write.
// It may be refilled in the same cycle its content is taken, so a steady stream never bubbles.
module wr_out_reg
  import pixel_pkg::*;
#(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = RGB444_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load;

  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  // Address and data change only on a load, so a stalled write holds steady.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = in_addr_i;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_addr_o  = addr_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/pixel_writer.sv
// Writes a raster frame of RGB888 pixels into a linear RGB444 frame buffer,
// after validating the header dimensions against the available address space.
module pixel_writer
  import pixel_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 17,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  pixel_writer_if.slave bus
);

  // Number of words between BASE_ADDR and the top of the address space.
  localparam logic [63:0] ADDR_SPACE = (64'd1 << ADDR_W) - 64'(BASE_ADDR);

  state_e              state_q, state_d;
  logic [15:0]         height_q, height_d;
  logic [15:0]         width_q, width_d;
  logic [15:0]         x_q, x_d;
  logic [15:0]         y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         area;
  logic                hdr_bad;
  logic                last_x;
  logic                last_pix;
  logic                in_valid;
  logic                in_ready;
  logic                pix_accept;
  logic                out_valid;
  logic [RGB444_W-1:0] pix_rgb;

  assign area       = 32'(height_q) * 32'(width_q);
  assign hdr_bad    = (height_q == 16'd0) || (width_q == 16'd0) || (64'(area) > ADDR_SPACE);
  assign last_x     = (x_q == width_q - 16'd1);
  assign last_pix   = last_x && (y_q == height_q - 16'd1);
  assign in_valid   = (state_q == ACTIVE) && bus.pix_valid;
  assign pix_accept = in_valid && in_ready;
  assign pix_rgb    = pack_rgb444(bus.pix_r, bus.pix_g, bus.pix_b);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.hdr_valid) state_d = CHECK;
      CHECK:   state_d = hdr_bad ? IDLE : ACTIVE;
      ACTIVE:  if (pix_accept && last_pix) state_d = DRAIN;
      DRAIN:   if (!out_valid || bus.wr_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // frame_done fires in the cycle the last pending write leaves the register.
  always_comb begin
    bus.pix_ready  = 1'b0;
    bus.frame_done = 1'b0;
    bus.hdr_err    = 1'b0;
    bus.busy       = (state_q != IDLE);
    case (state_q)
      CHECK:   bus.hdr_err    = hdr_bad;
      ACTIVE:  bus.pix_ready  = in_ready;
      DRAIN:   bus.frame_done = !out_valid || bus.wr_ready;
      default: ;
    endcase
  end

  always_comb begin
    height_d = height_q;
    width_d  = width_q;
    x_d      = x_q;
    y_d      = y_q;
    addr_d   = addr_q;
    case (state_q)
      IDLE: begin
        if (bus.hdr_valid) begin
          height_d = bus.height;
          width_d  = bus.width;
        end
      end
      CHECK: begin
        x_d    = '0;
        y_d    = '0;
        addr_d = BASE_ADDR;
      end
      ACTIVE: begin
        if (pix_accept) begin
          addr_d = addr_q + ADDR_W'(1);
          if (last_x) begin
            x_d = '0;
            y_d = y_q + 16'd1;
          end else begin
            x_d = x_q + 16'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      height_q <= '0;
      width_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
    end else begin
      height_q <= height_d;
      width_q  <= width_d;
      x_q      <= x_d;
      y_q      <= y_d;
      addr_q   <= addr_d;
    end
  end

  wr_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (RGB444_W)
  ) u_wr_out_reg (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_addr_i   (addr_q),
    .in_data_i   (pix_rgb),
    .out_valid_o (out_valid),
    .out_ready_i (bus.wr_ready),
    .out_addr_o  (bus.wr_addr),
    .out_data_o  (bus.wr_data)
  );

  assign bus.wr_en = out_valid;

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: every accepted pixel is turned into an
// expected (address, RGB444) write by a queue model and matched against the bus.
module tb_pixel_writer;
  import pixel_pkg::*;

  localparam int unsigned       ADDR_W    = 17;
  localparam logic [ADDR_W-1:0] BASE_ADDR = '0;
  localparam int                BUDGET    = 2000;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [RGB444_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pixel_writer_if #(.ADDR_W(ADDR_W)) bus ();

  pixel_writer #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int                  checkCount = 0;
  int                  passCount  = 0;
  int                  cycNum     = 0;
  int                  pixIdx;
  int                  frameTotal;
  int                  writeCount;
  int                  doneCount;
  int                  errCount;
  int                  firstWrCyc;
  int                  lastWrCyc;
  logic                stallPending = 1'b0;
  logic [ADDR_W-1:0]   stallAddr;
  logic [RGB444_W-1:0] stallData;
  logic [ADDR_W-1:0]   lastAddr;
  logic [RGB444_W-1:0] lastData;
  wr_t                 expQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount = checkCount + 1;
    assert (obs === exp) passCount = passCount + 1;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at the falling edge: what is visible now happens at the next rising edge.
  task automatic monitorCycle();
    wr_t e;
    wr_t got;
    int  d;
    if (stallPending) begin
      checkOutput("stall wr_en held", 32'(bus.wr_en), 32'd1);
      checkOutput("stall wr_addr held", 32'(bus.wr_addr), 32'(stallAddr));
      checkOutput("stall wr_data held", 32'(bus.wr_data), 32'(stallData));
    end
    stallPending = bus.wr_en && !bus.wr_ready;
    if (stallPending) begin
      checkOutput("pix_ready low in stall", 32'(bus.pix_ready), 32'd0);
      stallAddr = bus.wr_addr;
      stallData = bus.wr_data;
    end
    if (bus.wr_en && bus.wr_ready) begin
      checkOutput("write has model entry", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        checkOutput("wr_data", 32'(bus.wr_data), 32'(e.data));
      end
      got.addr   = bus.wr_addr;
      got.data   = bus.wr_data;
      lastAddr   = got.addr;
      lastData   = got.data;
      writeCount = writeCount + 1;
      if (firstWrCyc < 0) firstWrCyc = cycNum;
      lastWrCyc = cycNum;
    end
    if (bus.hdr_err) errCount = errCount + 1;
    if (bus.frame_done) begin
      doneCount = doneCount + 1;
      checkOutput("writes at frame_done", 32'(writeCount), 32'(frameTotal));
    end
    if (bus.pix_valid && bus.pix_ready) begin
      d = (int'(bus.pix_r) / 16) * 256 + (int'(bus.pix_g) / 16) * 16 + int'(bus.pix_b) / 16;
      e.addr = BASE_ADDR + ADDR_W'(pixIdx);
      e.data = d[RGB444_W-1:0];
      expQ.push_back(e);
      pixIdx = pixIdx + 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitorCycle();
    @(posedge clk);
    cycNum = cycNum + 1;
    #1;
  endtask

  task automatic drivePixel(input bit fixedPix);
    if (fixedPix) begin
      bus.pix_r = 8'hAB;
      bus.pix_g = 8'h3C;
      bus.pix_b = 8'hF0;
    end else begin
      bus.pix_r = 8'($urandom_range(255));
      bus.pix_g = 8'($urandom_range(255));
      bus.pix_b = 8'($urandom_range(255));
    end
  endtask

  task automatic clearModel(input int total);
    expQ.delete();
    pixIdx     = 0;
    writeCount = 0;
    doneCount  = 0;
    errCount   = 0;
    firstWrCyc = -1;
    lastWrCyc  = -1;
    frameTotal = total;
  endtask

  // mode 0: wr_ready always high; 1: wr_ready pattern 1,0,0,1; 2: random.
  task automatic applyStimulus(input int h, input int w, input int mode, input bit midHdr,
                               input bit fixedPix, input int abortAfter);
    int cyc;
    clearModel(h * w);
    bus.hdr_valid = 1'b1;
    bus.height    = 16'(h);
    bus.width     = 16'(w);
    bus.pix_valid = 1'b1;
    drivePixel(fixedPix);
    tick();
    checkOutput("busy in CHECK", 32'(bus.busy), 32'd1);
    cyc = 0;
    while (doneCount == 0 && cyc < BUDGET) begin
      if (abortAfter > 0 && pixIdx >= abortAfter) break;
      bus.hdr_valid = midHdr && (cyc == 4);
      bus.height    = 16'd7;
      bus.width     = 16'd9;
      case (mode)
        0:       bus.wr_ready = 1'b1;
        1:       bus.wr_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: bus.wr_ready = 1'($urandom_range(1));
      endcase
      bus.pix_valid = (pixIdx < frameTotal) && (mode == 0 || $urandom_range(3) != 0);
      drivePixel(fixedPix);
      tick();
      cyc = cyc + 1;
    end
    bus.pix_valid = 1'b0;
    bus.hdr_valid = 1'b0;
    if (abortAfter == 0) begin
      checkOutput("frame completed within budget", 32'(doneCount > 0), 32'd1);
      bus.wr_ready = 1'b1;
      tick();
      tick();
      checkOutput("frame_done pulses", 32'(doneCount), 32'd1);
      checkOutput("write count", 32'(writeCount), 32'(frameTotal));
      checkOutput("model drained", 32'(expQ.size()), 32'd0);
      checkOutput("busy after frame", 32'(bus.busy), 32'd0);
      if (mode == 0) checkOutput("back-to-back span", 32'(lastWrCyc - firstWrCyc), 32'(frameTotal - 1));
    end
  endtask

  task automatic badHeader(input int h, input int w);
    clearModel(0);
    bus.hdr_valid = 1'b1;
    bus.height    = 16'(h);
    bus.width     = 16'(w);
    bus.pix_valid = 1'b1;
    bus.wr_ready  = 1'b1;
    tick();
    bus.hdr_valid = 1'b0;
    checkOutput("busy in CHECK (bad hdr)", 32'(bus.busy), 32'd1);
    repeat (4) tick();
    bus.pix_valid = 1'b0;
    checkOutput("hdr_err pulses", 32'(errCount), 32'd1);
    checkOutput("writes after bad hdr", 32'(writeCount), 32'd0);
    checkOutput("busy after bad hdr", 32'(bus.busy), 32'd0);
  endtask

  task automatic checkResetOutputs(input string when);
    checkOutput({when, " wr_en"}, 32'(bus.wr_en), 32'd0);
    checkOutput({when, " wr_addr"}, 32'(bus.wr_addr), 32'd0);
    checkOutput({when, " wr_data"}, 32'(bus.wr_data), 32'd0);
    checkOutput({when, " pix_ready"}, 32'(bus.pix_ready), 32'd0);
    checkOutput({when, " frame_done"}, 32'(bus.frame_done), 32'd0);
    checkOutput({when, " hdr_err"}, 32'(bus.hdr_err), 32'd0);
    checkOutput({when, " busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.hdr_valid = 1'b0;
    bus.height    = '0;
    bus.width     = '0;
    bus.pix_valid = 1'b0;
    bus.pix_r     = '0;
    bus.pix_g     = '0;
    bus.pix_b     = '0;
    bus.wr_ready  = 1'b1;
    clearModel(0);

    #2 reset = 1'b0;
    #1 checkResetOutputs("power-on reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    $display("[TB] 2x3 frame, wr_ready high");
    applyStimulus(2, 3, 0, 1'b0, 1'b0, 0);

    $display("[TB] 2x3 frame, wr_ready 1,0,0,1");
    applyStimulus(2, 3, 1, 1'b0, 1'b0, 0);

    $display("[TB] rejected headers");
    badHeader(0, 5);
    badHeader(5, 0);
    badHeader(512, 512);
    badHeader(3, 43691);

    $display("[TB] 4x5 frame with mid-frame header");
    applyStimulus(4, 5, 2, 1'b1, 1'b0, 0);

    $display("[TB] random frames");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(int'($urandom_range(6, 1)), int'($urandom_range(6, 1)), 2, 1'b0, 1'b0, 0);
    end
    applyStimulus(1, 1, 1, 1'b0, 1'b0, 0);

    $display("[TB] reset mid-frame, then 1x1 frame");
    applyStimulus(4, 4, 0, 1'b0, 1'b0, 3);
    checkOutput("wr_en before reset", 32'(bus.wr_en), 32'd1);
    reset = 1'b0;
    stallPending = 1'b0;
    #1 checkResetOutputs("mid-frame reset");
    repeat (2) tick();
    reset = 1'b1;
    tick();
    applyStimulus(1, 1, 0, 1'b0, 1'b1, 0);
    checkOutput("1x1 address", 32'(lastAddr), 32'(BASE_ADDR));
    checkOutput("RGB444 pack", 32'(lastData), 32'h0A3F);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
